// File: rtl/psat_pkg.sv
// Shared lane geometry, FSM encoding and saturation limits for the
// packed saturating accumulator.
package psat_pkg;

   localparam int LANE_W = 4;
   localparam int LANES  = 4;
   localparam int DATA_W = LANE_W * LANES;

   localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
   localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

endpackage

// File: rtl/psat_lane.sv
// Single-lane signed saturating adder: clamps to the lane's extreme
// value on overflow and reports that overflow.
module psat_lane
   import psat_pkg::*;
(
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   output logic [LANE_W-1:0] sum,
   output logic              ovf
);

   logic [LANE_W-1:0] sum_raw;

   // Overflow only when both operands agree in sign and the result flips it.
   always_comb begin
      sum_raw = a + b;
      ovf     = (a[LANE_W-1] == b[LANE_W-1]) && (sum_raw[LANE_W-1] != a[LANE_W-1]);
      if (ovf) begin
         sum = a[LANE_W-1] ? SAT_NEG : SAT_POS;
      end else begin
         sum = sum_raw;
      end
   end

endmodule

// File: rtl/psat_acc.sv
// Four-lane packed saturating accumulator with sticky per-lane overflow
// flags, a saturating beat counter and a valid/ready result handshake.
module psat_acc
   import psat_pkg::*;
#(
   parameter int CNT_W = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [LANES-1:0]  out_sat,
   output logic [CNT_W-1:0]  out_count
);

   state_t             state_reg;
   logic [DATA_W-1:0]  acc_reg;
   logic [DATA_W-1:0]  acc_next;
   logic [LANES-1:0]   sat_reg;
   logic [LANES-1:0]   lane_ovf;
   logic [CNT_W-1:0]   count_reg;
   logic               accept;

   assign accept = (state_reg == ST_ACC) && in_valid;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         psat_lane u_lane (
            .a   (acc_reg[gi*LANE_W +: LANE_W]),
            .b   (in_data[gi*LANE_W +: LANE_W]),
            .sum (acc_next[gi*LANE_W +: LANE_W]),
            .ovf (lane_ovf[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_ACC;
         acc_reg   <= '0;
         sat_reg   <= '0;
         count_reg <= '0;
      end else begin
         case (state_reg)
            ST_ACC: begin
               if (accept) begin
                  acc_reg <= acc_next;
                  sat_reg <= sat_reg | lane_ovf;
                  // Counter pins at all-ones rather than wrapping.
                  if (count_reg != {CNT_W{1'b1}}) begin
                     count_reg <= count_reg + CNT_W'(1);
                  end
                  if (in_last) begin
                     state_reg <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_reg <= ST_ACC;
                  acc_reg   <= '0;
                  sat_reg   <= '0;
                  count_reg <= '0;
               end
            end
            default: state_reg <= ST_ACC;
         endcase
      end
   end

   // Every output comes straight from state, so nothing input-side leaks through.
   assign in_ready  = (state_reg == ST_ACC);
   assign out_valid = (state_reg == ST_DONE);
   assign out_data  = acc_reg;
   assign out_sat   = sat_reg;
   assign out_count = count_reg;

endmodule

// File: tb/tb_psat_acc.sv
// Directed bench for psat_acc: reset, sums, saturation, backpressure,
// mid-run reset and counter saturation on a narrow-counter instance.
module tb_psat_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_sat;
   logic [3:0]  out_count;

   logic        s_in_valid;
   logic        s_in_ready;
   logic [15:0] s_in_data;
   logic        s_in_last;
   logic        s_out_valid;
   logic        s_out_ready;
   logic [15:0] s_out_data;
   logic [3:0]  s_out_sat;
   logic [1:0]  s_out_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   psat_acc #(.CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_count (out_count)
   );

   psat_acc #(.CNT_W(2)) dut_small (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .in_last   (s_in_last),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_data  (s_out_data),
      .out_sat   (s_out_sat),
      .out_count (s_out_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
      $display("check %-14s observed=%h expected=%h", tag, observed, expected);
   endtask

   task automatic beat(input logic [15:0] data, input logic last);
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF; in_last = 1'b1; out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_data = 16'h0000; s_in_last = 1'b0; s_out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      check("rst_in_ready", 16'(in_ready), 16'h1);
      check("rst_out_valid", 16'(out_valid), 16'h0);
      check("rst_data", out_data, 16'h0000);
      check("rst_sat", 16'(out_sat), 16'h0);
      check("rst_count", 16'(out_count), 16'h0);

      // Single beat passes through untouched, result visible one cycle later.
      beat(16'h1F29, 1'b1);
      check("one_valid", 16'(out_valid), 16'h1);
      check("one_ready", 16'(in_ready), 16'h0);
      check("one_data", out_data, 16'h1F29);
      check("one_sat", 16'(out_sat), 16'h0);
      check("one_count", 16'(out_count), 16'h1);
      release_result();
      check("clr_valid", 16'(out_valid), 16'h0);
      check("clr_data", out_data, 16'h0000);
      check("clr_count", 16'(out_count), 16'h0);

      beat(16'h1F29, 1'b0);
      check("live_data", out_data, 16'h1F29);
      check("live_count", 16'(out_count), 16'h1);
      check("live_valid", 16'(out_valid), 16'h0);
      beat(16'h2137, 1'b1);
      check("sum_data", out_data, 16'h3050);
      check("sum_sat", 16'(out_sat), 16'h0);
      check("sum_count", 16'(out_count), 16'h2);
      release_result();

      beat(16'h5A3C, 1'b0);
      beat(16'h3C5A, 1'b1);
      check("sat2_data", out_data, 16'h7878);
      check("sat2_sat", 16'(out_sat), 16'hF);
      check("sat2_count", 16'(out_count), 16'h2);
      release_result();

      beat(16'h7777, 1'b0);
      beat(16'h1111, 1'b1);
      check("satp_data", out_data, 16'h7777);
      check("satp_sat", 16'(out_sat), 16'hF);

      // Backpressure: DONE must ignore incoming beats while held.
      in_valid = 1'b1; in_data = 16'hFFFF; in_last = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_data", out_data, 16'h7777);
         check("bp_sat", 16'(out_sat), 16'hF);
         check("bp_in_ready", 16'(in_ready), 16'h0);
         check("bp_valid", 16'(out_valid), 16'h1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      check("bp_rel_valid", 16'(out_valid), 16'h0);
      check("bp_rel_ready", 16'(in_ready), 16'h1);
      check("bp_rel_data", out_data, 16'h0000);
      check("bp_rel_sat", 16'(out_sat), 16'h0);

      // Reset mid-accumulation discards partial sums and flags.
      beat(16'h7777, 1'b0);
      beat(16'h1111, 1'b0);
      check("mid_sat", 16'(out_sat), 16'hF);
      rst = 1'b1; in_valid = 1'b1; in_data = 16'h1111;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      check("midrst_data", out_data, 16'h0000);
      check("midrst_sat", 16'(out_sat), 16'h0);
      check("midrst_count", 16'(out_count), 16'h0);

      beat(16'h1234, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("donerst_valid", 16'(out_valid), 16'h0);
      check("donerst_data", out_data, 16'h0000);

      // Two-bit counter pins at 3 after five beats.
      for (int i = 0; i < 5; i++) begin
         s_in_valid = 1'b1;
         s_in_data  = 16'h0000;
         s_in_last  = (i == 4);
         tick();
      end
      s_in_valid = 1'b0; s_in_last = 1'b0;
      check("cnt_sat", 16'(s_out_count), 16'h3);
      check("cnt_valid", 16'(s_out_valid), 16'h1);
      check("cnt_data", s_out_data, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/psat_acc.md
PSAT_ACC -- requirements
Module: psat_acc

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of the beat counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: upstream has a packed 4x4-bit vector on in_data.
REQ-005 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-006 SHALL have port in_data, input, 16: four signed 4-bit lanes; lane3=[15:12], lane0=[3:0].
REQ-007 SHALL have port in_last, input, 1: final beat of the current accumulation.
REQ-008 SHALL have port out_valid, output, 1: result is available.
REQ-009 SHALL have port out_ready, input, 1: downstream consumes the result.
REQ-010 SHALL have port out_data, output, 16: accumulated packed lanes.
REQ-011 SHALL have port out_sat, output, 4: sticky per-lane saturation flags; bit n is lane n.
REQ-012 SHALL have port out_count, output, CNT_W: number of beats accumulated.

Function
REQ-013 SHALL implement a two-state FSM: ACC (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-014 In ACC, a beat is accepted when in_valid=1; acc lane n SHALL become satadd(acc lane n, in_data lane n) for all four lanes in the same cycle.
REQ-015 satadd SHALL be a 4-bit two's-complement add. Overflow occurs when both operands have the same sign and the result sign differs. Positive overflow SHALL give 4'b0111 and negative overflow SHALL give 4'b1000. Otherwise the wrapped sum is used.
REQ-016 A lane overflow on any accepted beat SHALL set that lane's sat flag, which stays set until the accumulation is cleared.
REQ-017 out_count SHALL increment per accepted beat and saturate at 2^CNT_W-1 without wrapping.
REQ-018 Accepting a beat with in_last=1 SHALL move ACC to DONE, so out_valid rises the next cycle (latency 1); that beat is included in the result.
REQ-019 In DONE, out_data, out_sat and out_count SHALL hold stable while out_ready=0; in_valid SHALL be ignored.
REQ-020 In DONE with out_ready=1, the next state SHALL be ACC with acc, sat flags and count cleared to 0. The first accept after that SHALL be possible in the following cycle.
REQ-021 Accumulation SHALL start from zero, so a single-beat result equals in_data with no saturation.
REQ-022 out_data, out_sat and out_count SHALL reflect live accumulator state in ACC and frozen state in DONE.
REQ-023 The block SHALL contain no combinational path from in_valid, in_data, in_last or out_ready to any output.

Reset
REQ-024 When rst=1 at a clock edge, the state SHALL be ACC and acc, sat flags and count SHALL be 0. This gives out_valid=0, in_ready=1, out_data=16'h0000, out_sat=4'h0 and out_count=0.
REQ-025 Reset SHALL take priority over any simultaneous accept or out_ready, including mid-accumulation and in DONE; partial results SHALL be discarded.

Structure
REQ-026 A shared package SHALL hold the lane width (4), the lane count (4), the state encoding (ACC, DONE), and the saturation constants 4'b0111 and 4'b1000.
REQ-027 One sub-module, psat_lane, SHALL implement a single-lane satadd with an overflow output and SHALL be instantiated four times.

Verification
REQ-028 Reset: assert rst for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_data=16'h0000, out_sat=0, out_count=0.
REQ-029 Single beat: 16'h1F29 with last -> next cycle out_valid=1, out_data=16'h1F29, out_sat=4'h0, out_count=1.
REQ-030 Non-saturating sum: beats 16'h1F29, then 16'h2137 with last -> out_data=16'h3050, out_sat=4'h0, out_count=2.
REQ-031 Saturation both ways: beats 16'h5A3C, then 16'h3C5A with last -> out_data=16'h7878, out_sat=4'hF. Separately, beats 16'h7777 then 16'h1111 -> 16'h7777, out_sat=4'hF.
REQ-032 Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with 16'hFFFF -> outputs unchanged, in_ready=0. Then pulse out_ready=1 -> next cycle state is ACC with out_data=0.
REQ-033 Reset and counter limit: assert rst after 2 beats -> all cleared. With CNT_W=2, send 5 beats of 16'h0000 with last on the 5th -> out_count=3.
